lsu_mem_master: RTL
===================

// Module: lsu_mem_master
// PURPOSE
//  - Load/store initiator between the MEM pipeline stage and the word-only data memory.
//  - Accepts one byte/half/word load or store, then drives word-aligned memory requests.
//  - Sub-word stores use a read-modify-write sequence.
//  - Loads are extracted and sign- or zero-extended; misaligned accesses are rejected.
//  - Single outstanding access; the pipeline stalls while req_ready is low.
// PARAMETERS
//  - AW      32  address width; mem_addr[1:0] is always 0
//  - DW      32  data width; fixed at 32, four byte lanes, little-endian
// PORTS
//  - clk         in   1   clock, rising edge
//  - clr_n       in   1   reset, asynchronous, active-low
//  - req_valid   in   1   MEM stage presents an access
//  - req_ready   out  1   block idle, access accepted when valid&ready
//  - req_we      in   1   1=store, 0=load
//  - req_size    in   2   0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
//  - req_sext    in   1   loads: 1=sign-extend, 0=zero-extend
//  - req_addr    in   AW  byte address
//  - req_wdata   in   DW  store data, right-justified
//  - req_pc      in   32  PC of the instruction, used for trace only
//  - rsp_valid   out  1   one-cycle completion pulse; no backpressure
//  - rsp_rdata   out  DW  extended load data; 0 for stores and errors
//  - rsp_err     out  1   misaligned/reserved-size access, valid with rsp_valid
//  - mem_req     out  1   memory request; held until mem_gnt
//  - mem_we      out  1   memory write strobe, qualified by mem_req
//  - mem_addr    out  AW  word address, low two bits zero
//  - mem_wdata   out  DW  full word to write
//  - mem_gnt     in   1   request taken this cycle (write completes on grant)
//  - mem_rvalid  in   1   read data valid, at least 1 cycle after mem_gnt
//  - mem_rdata   in   DW  read word
// BEHAVIOUR
//  - Reset values: all outputs 0 except req_ready=1; FSM=IDLE; captured request regs 0.
//  - FSM IDLE->RD: load, or aligned sub-word store.
//  - FSM IDLE->WR: aligned word store.
//  - FSM IDLE->RESP: misaligned access (half with addr[0]!=0, word with addr[1:0]!=0,
//    size 3); rsp_err=1; no memory access.
//  - FSM RD: mem_req=1, mem_we=0; on mem_gnt -> RD_WAIT.
//  - FSM RD_WAIT: on mem_rvalid, a load -> RESP; a store merges lanes into mem_wdata -> WR.
//  - FSM WR: mem_req=1, mem_we=1; on mem_gnt -> RESP.
//  - FSM RESP: rsp_valid=1 for exactly one cycle -> IDLE.
//  - req_ready=1 only in IDLE. Accept is on the edge where valid&ready; inputs are not
//    sampled again until the next IDLE.
//  - Best-case latency, accept edge to rsp_valid (all outputs registered):
//    word load 3 cycles; word store 2; sub-word store 4; error 1.
//  - Byte lane = addr[1:0]; half lane = addr[1]. Store merge replaces only the addressed
//    lanes with the low bits of req_wdata.
//  - Load extract: the selected lane is placed at bits [7:0]/[15:0]; upper bits are its MSB
//    when req_sext=1, else 0.
//  - Boundaries:
//    - mem_gnt in the same cycle mem_req rises is legal.
//    - mem_rvalid outside RD_WAIT is ignored.
//    - Address 0xFFFFFFFC is a legal word access; there is no wrap check.
//    - Reset asserted mid-operation forces IDLE asynchronously and drops mem_req at once;
//      a partial RMW is abandoned with no write issued.
// CONFIGURATION
//  - LSU_TRACE_EN defined: on each WR grant, $display("%d@%h: *%h <= %h", $time,
//    captured pc, mem_addr, mem_wdata) prints the full merged word.
//  - LSU_TRACE_EN undefined: no display; req_pc is unused; RTL is otherwise identical.
// STRUCTURE
//  - Package mips_mem_pkg:
//    - size enum SZ_BYTE/SZ_HALF/SZ_WORD;
//    - FSM state enum;
//    - function is_misaligned(size, addr[1:0]).
//  - Sub-module lsu_lane_unit (combinational): store merge (old word, data, size,
//    offset -> new word) and load extract (word, size, offset, sext -> result).
//  - FSM and request/response registers live in lsu_mem_master.
// TESTING
//  - lw 0x10, gnt immediate, rvalid +1, mem 0x10 = 0xDEADBEEF
//    -> mem_addr=0x10; rsp_rdata=0xDEADBEEF 3 cycles after accept; rsp_err=0.
//  - lb sext at 0x13 and lbu at 0x13, word 0x80FF7F01 -> 0xFFFFFF80 and 0x00000080.
//    lh sext at 0x12 -> 0xFFFF80FF.
//  - sb 0xAB at 0x21, old word 0x11223344 -> read issued, then write
//    mem_wdata=0x1122AB44 at mem_addr=0x20; rsp_valid after write grant.
//  - sw at 0x06 and lh at 0x03 -> rsp_err=1 next cycle; mem_req never asserted.
//  - sh 0xBEEF at 0x42, mem_gnt withheld 5 cycles -> mem_req/addr/we held stable;
//    req_ready=0 throughout; result word 0xBEEFxxxx with the low half unchanged.
//  - clr_n pulsed low in RD_WAIT of an sb -> mem_req=0 immediately; no write issued;
//    req_ready=1 after release; next lw completes normally.
//  - With LSU_TRACE_EN, the sb test prints one line containing "00000020 <= 1122ab44".

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - access sizes, LSU FSM states and alignment helper
package mips_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  // Size code 3 is reserved and reported the same way as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = |off;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// rtl/lsu_lane_unit.sv - byte-lane store merge and load extract/extend
module lsu_lane_unit
  import mips_mem_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sext,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mem_word[{offset, 3'b000} +: 8];
  assign half_sel = mem_word[{offset[1], 4'b0000} +: 16];

  // Replace only the addressed lanes of the old word; pick and extend the addressed lanes for loads.
  always_comb begin
    merged    = mem_word;
    extracted = mem_word;
    case (size)
      SZ_BYTE: begin
        merged[{offset, 3'b000} +: 8] = st_data[7:0];
        extracted = {{24{sext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        merged[{offset[1], 4'b0000} +: 16] = st_data[15:0];
        extracted = {{16{sext & half_sel[15]}}, half_sel};
      end
      default: begin
        merged    = st_data;
        extracted = mem_word;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator to word memory; LSU_TRACE_EN enables write trace
module lsu_mem_master #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_sext,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [31:0]   req_pc,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);
  import mips_mem_pkg::*;

  lsu_state_e    state_q, state_d;
  logic          we_q;
  logic [1:0]    size_q;
  logic          sext_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          accept;
  logic          misaligned;
  logic [DW-1:0] merged;
  logic [DW-1:0] extracted;

  assign accept     = req_valid && (state_q == ST_IDLE);
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);

  lsu_lane_unit u_lane (
    .mem_word  (mem_rdata),
    .st_data   (wdata_q),
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .sext      (sext_q),
    .merged    (merged),
    .extracted (extracted)
  );

  // State register; reset drops straight to IDLE, abandoning any partial read-modify-write.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: sub-word stores read first, word stores write directly, bad accesses answer at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (misaligned)                              state_d = ST_RESP;
          else if (req_we && (req_size == SZ_WORD))    state_d = ST_WR;
          else                                         state_d = ST_RD;
        end
      end
      ST_RD:      if (mem_gnt)    state_d = ST_RD_WAIT;
      ST_RD_WAIT: if (mem_rvalid) state_d = we_q ? ST_WR : ST_RESP;
      ST_WR:      if (mem_gnt)    state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Capture the request on accept; fold returned read data into the store word or load result.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      sext_q  <= req_sext;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
      err_q   <= misaligned;
    end else if ((state_q == ST_RD_WAIT) && mem_rvalid) begin
      if (we_q) wdata_q <= merged;
      else      rdata_q <= extracted;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_req   = (state_q == ST_RD) || (state_q == ST_WR);
  assign mem_we    = (state_q == ST_WR);
  assign mem_addr  = {addr_q[AW-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
  assign rsp_err   = (state_q == ST_RESP) && err_q;

`ifdef LSU_TRACE_EN
  logic [31:0] pc_q;

  // Keep the PC of the accepted access and print every granted memory write.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_q <= '0;
    end else begin
      if (accept) pc_q <= req_pc;
      if ((state_q == ST_WR) && mem_gnt)
        $display("%d@%h: *%h <= %h", $time, pc_q, mem_addr, mem_wdata);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule
